// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, address-width
// helper and the write-port priority used by both the storage array and the bypass.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    // Port 1 carries the later pipeline stage, so it wins a same-address collision.
    localparam bit WR_PRIO_PORT1 = 1'b1;

    function automatic int rf_addr_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: range and zero-register checks, write-through bypass
// from both write ports, and the pending-flag lookup.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int AW       = rf_addr_w(RF_NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                         active,
    input  logic [AW-1:0]                addr,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    input  logic [NUM_REGS-1:0]          busy_vec,
    input  logic                         we0,
    input  logic [AW-1:0]                wa0,
    input  logic [DATA_W-1:0]            wd0,
    input  logic                         we1,
    input  logic [AW-1:0]                wa1,
    input  logic [DATA_W-1:0]            wd1,
    output logic [DATA_W-1:0]            data,
    output logic                         busy
);

    logic              in_range;
    logic              is_zero;
    logic              hit0;
    logic              hit1;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] stored;

    assign in_range = ({1'b0, addr} < (AW+1)'(NUM_REGS));
    assign is_zero  = (ZERO_REG != 0) && (addr == '0);
    assign hit0     = we0 && (wa0 == addr);
    assign hit1     = we1 && (wa1 == addr);

    // Clamp the index so an out-of-range address never selects outside the array.
    assign idx    = in_range ? addr : '0;
    assign stored = regs_flat[int'(idx)*DATA_W +: DATA_W];

    always_comb begin
        data = '0;
        if (active && in_range && !is_zero) begin
            if (hit0 && hit1)
                data = WR_PRIO_PORT1 ? wd1 : wd0;
            else if (hit1)
                data = wd1;
            else if (hit0)
                data = wd0;
            else
                data = stored;
        end
    end

    // A same-cycle late writeback retires the producer, so the flag drops immediately.
    assign busy = active && in_range && !is_zero && busy_vec[idx] && !hit1;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, write-through bypass, optional
// hardwired zero register and a per-register pending scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [AW-1:0]            wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [AW-1:0]            wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     mark_en,
    input  logic [AW-1:0]            mark_addr
);

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS-1:0]        busy;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        wr0_hit;
    logic [NUM_REGS-1:0]        wr1_hit;
    logic [NUM_REGS-1:0]        clr_hit;
    logic [NUM_REGS-1:0]        mark_hit;

    // Per-register decode; addresses beyond NUM_REGS simply match nothing.
    always_comb begin
        wr0_hit  = '0;
        wr1_hit  = '0;
        clr_hit  = '0;
        mark_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            clr_hit[r] = we1 && (wa1 == AW'(r));
            if (!((ZERO_REG != 0) && (r == 0))) begin
                wr0_hit[r]  = we0 && (wa0 == AW'(r));
                wr1_hit[r]  = we1 && (wa1 == AW'(r));
                mark_hit[r] = mark_en && (mark_addr == AW'(r));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr0_hit[r] && wr1_hit[r])
                    regs[r] <= WR_PRIO_PORT1 ? wd1 : wd0;
                else if (wr1_hit[r])
                    regs[r] <= wd1;
                else if (wr0_hit[r])
                    regs[r] <= wd0;
            end
        end
    end

    // A mark in the same cycle as a clear means a new producer was issued: mark wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                busy[r] <= mark_hit[r] | (busy[r] & ~clr_hit[r]);
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NUM_REGS; r++)
            regs_flat[r*DATA_W +: DATA_W] = regs[r];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .active    (rst_n),
            .addr      (rd_addr[k*AW +: AW]),
            .regs_flat (regs_flat),
            .busy_vec  (busy),
            .we0       (we0),
            .wa0       (wa0),
            .wd0       (wd0),
            .we1       (we1),
            .wa1       (wa1),
            .wd1       (wd1),
            .data      (rd_data[k*DATA_W +: DATA_W]),
            .busy      (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two register-file builds (default, and 64-bit/24-reg/3-port/no-zero)
// share one stimulus stream and are checked against an array-based reference model.
module tb_reg_file_mp;

    typedef struct packed {
        logic            we0;
        logic [4:0]      wa0;
        logic [63:0]     wd0;
        logic            we1;
        logic [4:0]      wa1;
        logic [63:0]     wd1;
        logic            mark_en;
        logic [4:0]      mark_addr;
        logic [2:0][4:0] ra;
    } stim_t;

    typedef struct packed {
        logic [1:0][2:0][63:0] data;
        logic [1:0][2:0]       busy;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          we0, we1, mark_en;
    logic [4:0]    wa0, wa1, mark_addr;
    logic [63:0]   wd0, wd1;
    logic [9:0]    rd_addr_a;
    logic [63:0]   rd_data_a;
    logic [1:0]    rd_busy_a;
    logic [14:0]   rd_addr_b;
    logic [191:0]  rd_data_b;
    logic [2:0]    rd_busy_b;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];

    reg_file_mp dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr_a),
        .rd_data   (rd_data_a),
        .rd_busy   (rd_busy_a),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0[31:0]),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1[31:0]),
        .mark_en   (mark_en),
        .mark_addr (mark_addr)
    );

    reg_file_mp #(.DATA_W(64), .NUM_REGS(24), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr_b),
        .rd_data   (rd_data_b),
        .rd_busy   (rd_busy_b),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .mark_en   (mark_en),
        .mark_addr (mark_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nregs(input int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic bit zreg(input int d);
        return (d == 0);
    endfunction

    function automatic int nrd(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] dmask(input int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Value a reader sees this cycle: newest write wins, then the stored value.
    function automatic logic [63:0] exp_data(input int d, input stim_t s, input int a);
        if (a >= nregs(d)) return 64'h0;
        if (zreg(d) && a == 0) return 64'h0;
        if (s.we1 && int'(s.wa1) == a) return s.wd1 & dmask(d);
        if (s.we0 && int'(s.wa0) == a) return s.wd0 & dmask(d);
        return m_regs[d][a];
    endfunction

    function automatic logic exp_busy(input int d, input stim_t s, input int a);
        if (a >= nregs(d)) return 1'b0;
        if (zreg(d) && a == 0) return 1'b0;
        if (s.we1 && int'(s.wa1) == a) return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic void commit(input int d, input stim_t s);
        int a0, a1, am;
        a0 = int'(s.wa0);
        a1 = int'(s.wa1);
        am = int'(s.mark_addr);
        if (s.we0 && a0 < nregs(d) && !(zreg(d) && a0 == 0)) m_regs[d][a0] = s.wd0 & dmask(d);
        if (s.we1 && a1 < nregs(d) && !(zreg(d) && a1 == 0)) m_regs[d][a1] = s.wd1 & dmask(d);
        if (s.we1 && a1 < nregs(d)) m_busy[d][a1] = 1'b0;
        if (s.mark_en && am < nregs(d) && !(zreg(d) && am == 0)) m_busy[d][am] = 1'b1;
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_regs[d][r] = 64'h0;
                m_busy[d][r] = 1'b0;
            end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.we0       = 1'($urandom_range(0, 1));
        s.wa0       = rand_addr();
        s.wd0       = {$urandom(), $urandom()};
        s.we1       = ($urandom_range(0, 2) == 0);
        s.wa1       = rand_addr();
        s.wd1       = {$urandom(), $urandom()};
        s.mark_en   = ($urandom_range(0, 2) == 0);
        s.mark_addr = rand_addr();
        for (int k = 0; k < 3; k++) s.ra[k] = rand_addr();
        return s;
    endfunction

    // One cycle: drive after the edge, queue what the readers must see, advance the model.
    task automatic step(input stim_t s, input bit assert_rst);
        exp_t e;
        @(posedge clk);
        #1;
        we0       = s.we0;
        wa0       = s.wa0;
        wd0       = s.wd0;
        we1       = s.we1;
        wa1       = s.wa1;
        wd1       = s.wd1;
        mark_en   = s.mark_en;
        mark_addr = s.mark_addr;
        rd_addr_a = {s.ra[1], s.ra[0]};
        rd_addr_b = s.ra;
        e = '0;
        if (assert_rst) begin
            #2;
            rst_n = 1'b0;
            model_clear();
        end else begin
            rst_n = 1'b1;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < nrd(d); k++) begin
                    e.data[d][k] = exp_data(d, s, int'(s.ra[k]));
                    e.busy[d][k] = exp_busy(d, s, int'(s.ra[k]));
                end
            commit(0, s);
            commit(1, s);
        end
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        logic        actb;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < nrd(d); k++) begin
                    act  = (d == 0) ? {32'h0, rd_data_a[k*32 +: 32]} : rd_data_b[k*64 +: 64];
                    actb = (d == 0) ? rd_busy_a[k] : rd_busy_b[k];
                    checks++;
                    if (act !== e.data[d][k]) begin
                        errors++;
                        $display("FAIL rd_data dut%0d port%0d t=%0t: got %h expected %h",
                                 d, k, $time, act, e.data[d][k]);
                    end
                    checks++;
                    if (actb !== e.busy[d][k]) begin
                        errors++;
                        $display("FAIL rd_busy dut%0d port%0d t=%0t: got %b expected %b",
                                 d, k, $time, actb, e.busy[d][k]);
                    end
                end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        we0 = 0; we1 = 0; mark_en = 0;
        wa0 = '0; wa1 = '0; mark_addr = '0;
        wd0 = '0; wd1 = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_clear();
        repeat (2) @(posedge clk);
        step(idle(), 1'b1);
        s = idle(); s.ra[0] = 5; s.ra[1] = 31; s.ra[2] = 3;
        step(s, 1'b0);

        // write then read, plus same-cycle bypass
        s = idle(); s.we0 = 1; s.wa0 = 11; s.wd0 = 64'hD; s.ra[1] = 11; s.ra[0] = 12;
        step(s, 1'b0);
        s = idle(); s.ra[0] = 11; s.ra[2] = 11;
        step(s, 1'b0);

        // collision on r7
        s = idle(); s.we0 = 1; s.wa0 = 7; s.wd0 = 64'hAAAA_AAAA;
        s.we1 = 1; s.wa1 = 7; s.wd1 = 64'h5555_5555; s.ra = {5'd7, 5'd7, 5'd7};
        step(s, 1'b0);
        s = idle(); s.ra = {5'd7, 5'd7, 5'd7};
        step(s, 1'b0);

        // register 0
        s = idle(); s.we0 = 1; s.wa0 = 0; s.wd0 = 64'hFFFF_FFFF;
        s.mark_en = 1; s.mark_addr = 0;
        step(s, 1'b0);
        s = idle();
        step(s, 1'b0);

        // scoreboard on r9
        s = idle(); s.mark_en = 1; s.mark_addr = 9; s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.we1 = 1; s.wa1 = 9; s.wd1 = 64'h99; s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.mark_en = 1; s.mark_addr = 9; s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.mark_en = 1; s.mark_addr = 9; s.we1 = 1; s.wa1 = 9; s.wd1 = 64'h19; s.ra[0] = 9;
        step(s, 1'b0);
        s = idle(); s.ra[0] = 9; s.ra[1] = 9;
        step(s, 1'b0);

        // fill every address, then read all on every port (24..31 out of range for dut_b)
        for (int r = 0; r < 32; r++) begin
            s = idle(); s.we0 = 1; s.wa0 = 5'(r);
            s.wd0 = {32'hC0DE_0000 | 32'(r), 32'hA500_0000 | 32'(r * 3)};
            step(s, 1'b0);
        end
        for (int r = 0; r < 32; r++) begin
            s = idle();
            s.ra = {5'((r + 2) % 32), 5'((r + 1) % 32), 5'(r)};
            step(s, 1'b0);
        end

        // reset pulse with writes and marks in flight
        s = rand_stim(); s.we0 = 1; s.we1 = 1; s.mark_en = 1;
        step(s, 1'b1);
        s = idle(); s.ra = {5'd0, 5'd31, 5'd5};
        step(s, 1'b0);
        s = idle(); s.ra = {5'd7, 5'd11, 5'd9};
        step(s, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) step(rand_stim(), 1'b1);
            else step(rand_stim(), 1'b0);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
